// File: rtl/ifid_hazard_stage_pkg.sv
// Shared pipeline definitions: instruction field positions, NOP encoding, stall FSM states.
package pipe_pkg;

  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [4:0]  REG_ZERO  = 5'd0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } stall_state_e;

  function automatic logic [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/ifid_hazard_stage_hazard_detect.sv
// Load-use hazard compare: the load in EX writes a register the instruction in ID may read.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic       valid_i,
  input  logic       mem_to_reg_i,
  input  logic [4:0] ex_rt_i,
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  output logic       hazard_o
);

  // Rt is compared even for instructions that never read it; a spurious stall is safe.
  assign hazard_o = valid_i & mem_to_reg_i & (ex_rt_i != REG_ZERO) &
                    ((ex_rt_i == rs_i) | (ex_rt_i == rt_i));

endmodule

// File: rtl/ifid_hazard_stage.sv
// IF/ID register with load-use stall control (RUN/HOLD FSM, 4-bit stall counter).
// Optional HAZARD_STATS_EN adds a saturating stall_count output.
module ifid_hazard_stage
  import pipe_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int PC_W              = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_valid,
  input  logic [31:0]     instr_in,
  input  logic [PC_W-1:0] pc_in,
  input  logic            flush,
  input  logic            ex_MemToReg,
  input  logic [4:0]      ex_Rt_a,
  output logic            pc_write,
  output logic            valid_out,
  output logic [31:0]     instr_out,
  output logic [PC_W-1:0] pc_out,
  output logic [4:0]      Rs_a,
  output logic [4:0]      Rt_a,
  output logic [4:0]      Rd_a,
  output logic [31:0]     immediate,
  output logic            bubble
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]     stall_count
`endif
);

  localparam logic [3:0] HOLD_INIT =
    (LOAD_STALL_CYCLES > 1) ? 4'(LOAD_STALL_CYCLES - 2) : 4'd0;

  logic [31:0]     instr_q, instr_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  stall_state_e    state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            hazard;
  logic            hz_stall;

  hazard_detect u_hazard_detect (
    .valid_i      (valid_q),
    .mem_to_reg_i (ex_MemToReg),
    .ex_rt_i      (ex_Rt_a),
    .rs_i         (Rs_a),
    .rt_i         (Rt_a),
    .hazard_o     (hazard)
  );

  always_comb begin
    instr_d  = instr_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    hz_stall = 1'b0;
    if (flush) begin
      instr_d = NOP_INSTR;
      pc_d    = '0;
      valid_d = 1'b0;
      state_d = ST_RUN;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hazard) begin
            hz_stall = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d = ST_HOLD;
              cnt_d   = HOLD_INIT;
            end
          end else begin
            valid_d = fetch_valid;
            instr_d = fetch_valid ? instr_in : NOP_INSTR;
            pc_d    = pc_in;
          end
        end
        ST_HOLD: begin
          // Stall runs to completion; the hazard is not re-checked here.
          hz_stall = 1'b1;
          if (cnt_q == 4'd0) state_d = ST_RUN;
          else               cnt_d   = cnt_q - 4'd1;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      valid_q <= 1'b0;
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A flush forces a bubble but lets the PC advance to the redirect target.
  assign bubble   = rst_n & (flush | hz_stall);
  assign pc_write = ~rst_n | flush | ~hz_stall;

  assign valid_out = valid_q;
  assign instr_out = instr_q;
  assign pc_out    = pc_q;
  assign Rs_a      = instr_q[RS_MSB:RS_LSB];
  assign Rt_a      = instr_q[RT_MSB:RT_LSB];
  assign Rd_a      = instr_q[RD_MSB:RD_LSB];
  assign immediate = sign_ext16(instr_q[IMM_MSB:IMM_LSB]);

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hz_stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= 32'd0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifid_hazard_stage.sv
// Bench: two instances (1-cycle and 3-cycle load stall) share stimulus; each is checked against a stall-budget model.
module tb_ifid_hazard_stage;

  logic        clk;
  logic        rst_n;
  logic        fetch_valid;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        flush;
  logic        ex_MemToReg;
  logic [4:0]  ex_Rt_a;

  logic [1:0]  pcw_o, valid_o, bubble_o;
  logic [31:0] instr_o [2];
  logic [31:0] pc_o    [2];
  logic [4:0]  rs_o    [2];
  logic [4:0]  rt_o    [2];
  logic [4:0]  rd_o    [2];
  logic [31:0] imm_o   [2];
`ifdef HAZARD_STATS_EN
  logic [31:0] sc_o    [2];
`endif

  ifid_hazard_stage #(.LOAD_STALL_CYCLES(1), .PC_W(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .instr_in(instr_in), .pc_in(pc_in),
    .flush(flush), .ex_MemToReg(ex_MemToReg), .ex_Rt_a(ex_Rt_a), .pc_write(pcw_o[0]),
    .valid_out(valid_o[0]), .instr_out(instr_o[0]), .pc_out(pc_o[0]), .Rs_a(rs_o[0]),
    .Rt_a(rt_o[0]), .Rd_a(rd_o[0]), .immediate(imm_o[0]), .bubble(bubble_o[0])
`ifdef HAZARD_STATS_EN
    , .stall_count(sc_o[0])
`endif
  );

  ifid_hazard_stage #(.LOAD_STALL_CYCLES(3), .PC_W(32)) dut3 (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .instr_in(instr_in), .pc_in(pc_in),
    .flush(flush), .ex_MemToReg(ex_MemToReg), .ex_Rt_a(ex_Rt_a), .pc_write(pcw_o[1]),
    .valid_out(valid_o[1]), .instr_out(instr_o[1]), .pc_out(pc_o[1]), .Rs_a(rs_o[1]),
    .Rt_a(rt_o[1]), .Rd_a(rd_o[1]), .immediate(imm_o[1]), .bubble(bubble_o[1])
`ifdef HAZARD_STATS_EN
    , .stall_count(sc_o[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int stall_len [2] = '{1, 3};

  // Reference model: IF/ID contents plus "stall cycles still owed" per instance.
  bit          m_valid [2];
  logic [31:0] m_instr [2];
  logic [31:0] m_pc    [2];
  int          m_left  [2];
  longint      m_stats [2];
  bit          exp_bub [2];
  bit          exp_pcw [2];
  bit          obs_bub [2];
  bit          obs_pcw [2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 0; m_instr[k] = 32'h0; m_pc[k] = 32'h0; m_left[k] = 0; m_stats[k] = 0;
    end
  endfunction

  // Drives one cycle of inputs, samples bubble/pc_write before the edge, advances the model.
  task automatic step(input bit fv, input logic [31:0] ins, input logic [31:0] pc,
                      input bit fl, input bit mem, input logic [4:0] rt);
    bit hz;
    fetch_valid = fv; instr_in = ins; pc_in = pc; flush = fl; ex_MemToReg = mem; ex_Rt_a = rt;
    #2;
    for (int k = 0; k < 2; k++) begin
      obs_bub[k] = bubble_o[k];
      obs_pcw[k] = pcw_o[k];
      hz = m_valid[k] && mem && (rt != 5'd0) &&
           (rt == m_instr[k][25:21] || rt == m_instr[k][20:16]);
      if (fl) begin
        exp_bub[k] = 1; exp_pcw[k] = 1;
        m_instr[k] = 32'h0; m_valid[k] = 0; m_pc[k] = 32'h0; m_left[k] = 0;
      end else if (m_left[k] > 0) begin
        exp_bub[k] = 1; exp_pcw[k] = 0; m_left[k]--; m_stats[k]++;
      end else if (hz) begin
        exp_bub[k] = 1; exp_pcw[k] = 0; m_left[k] = stall_len[k] - 1; m_stats[k]++;
      end else begin
        exp_bub[k] = 0; exp_pcw[k] = 1;
        m_valid[k] = fv; m_instr[k] = fv ? ins : 32'h0; m_pc[k] = pc;
      end
    end
    @(posedge clk); #1;
    cyc++;
    $display("cyc %0d fv=%0d instr=%08h pc=%08h flush=%0d mem=%0d ex_rt=%0d | bubble=%0d/%0d pc_write=%0d/%0d",
             cyc, fv, ins, pc, fl, mem, rt, obs_bub[0], obs_bub[1], obs_pcw[0], obs_pcw[1]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; fetch_valid = 0; instr_in = 0; pc_in = 0; flush = 0; ex_MemToReg = 0; ex_Rt_a = 0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b1; fetch_valid = 0; instr_in = 0; pc_in = 0; ex_MemToReg = 0; ex_Rt_a = 0;
    #3;
    for (int k = 0; k < 2; k++) begin
      checks++; if (valid_o[k] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d] got %0d want 0", k, valid_o[k]); end
      checks++; if (instr_o[k] !== 32'h0) begin errors++; $display("FAIL reset_instr[%0d] got %08h want 0", k, instr_o[k]); end
      checks++; if (bubble_o[k] !== 1'b0) begin errors++; $display("FAIL reset_bubble[%0d] got %0d want 0", k, bubble_o[k]); end
      checks++; if (pcw_o[k] !== 1'b1) begin errors++; $display("FAIL reset_pc_write[%0d] got %0d want 1", k, pcw_o[k]); end
    end
    do_reset();
  endtask

  task automatic test_fetch();
    step(1, 32'h8C22_0004, 32'h10, 0, 0, 5'd0);
    for (int k = 0; k < 2; k++) begin
      checks++; if (instr_o[k] !== 32'h8C22_0004) begin errors++; $display("FAIL fetch_instr[%0d] got %08h want 8c220004", k, instr_o[k]); end
      checks++; if (pc_o[k] !== 32'h10) begin errors++; $display("FAIL fetch_pc[%0d] got %08h want 10", k, pc_o[k]); end
      checks++; if (rs_o[k] !== 5'd1 || rt_o[k] !== 5'd2) begin errors++; $display("FAIL fetch_rs_rt[%0d] got %0d/%0d want 1/2", k, rs_o[k], rt_o[k]); end
      checks++; if (imm_o[k] !== 32'd4) begin errors++; $display("FAIL fetch_imm[%0d] got %08h want 4", k, imm_o[k]); end
      checks++; if (valid_o[k] !== 1'b1) begin errors++; $display("FAIL fetch_valid[%0d] got %0d want 1", k, valid_o[k]); end
    end
  endtask

  // One hazard, then four free cycles: 1-cycle instance stalls once, 3-cycle instance three times.
  task automatic test_load_use_stall();
    bit want_b [2][5];
    want_b[0] = '{1, 0, 0, 0, 0};
    want_b[1] = '{1, 1, 1, 0, 0};
    step(1, 32'h0043_0820, 32'h14, 0, 0, 5'd0);
    step(1, 32'h2001_FFFF, 32'h18, 0, 1, 5'd2);
    for (int k = 0; k < 2; k++) begin
      checks++; if (obs_bub[k] !== 1'b1 || obs_pcw[k] !== 1'b0) begin errors++;
        $display("FAIL hazard_ctrl[%0d] got bubble=%0d pc_write=%0d want 1/0", k, obs_bub[k], obs_pcw[k]); end
      checks++; if (instr_o[k] !== 32'h0043_0820) begin errors++; $display("FAIL hazard_hold[%0d] got %08h want 00430820", k, instr_o[k]); end
    end
    for (int i = 1; i < 5; i++) begin
      step(1, 32'h2001_FFFF, 32'h18, 0, 0, 5'd0);
      for (int k = 0; k < 2; k++) begin
        checks++; if (obs_bub[k] !== want_b[k][i] || obs_pcw[k] !== !want_b[k][i]) begin errors++;
          $display("FAIL stall_len[%0d] cycle %0d got bubble=%0d pc_write=%0d want bubble=%0d", k, i, obs_bub[k], obs_pcw[k], want_b[k][i]); end
      end
    end
    for (int k = 0; k < 2; k++) begin
      checks++; if (imm_o[k] !== 32'hFFFF_FFFF || instr_o[k] !== 32'h2001_FFFF) begin errors++;
        $display("FAIL resume[%0d] got instr=%08h imm=%08h want 2001ffff/ffffffff", k, instr_o[k], imm_o[k]); end
    end
  endtask

  task automatic test_no_stall();
    step(1, 32'h0005_0000, 32'h20, 0, 0, 5'd0);
    step(1, 32'h0007_0000, 32'h24, 0, 1, 5'd0);
    for (int k = 0; k < 2; k++) begin
      checks++; if (obs_bub[k] !== 1'b0 || obs_pcw[k] !== 1'b1) begin errors++;
        $display("FAIL rt_zero[%0d] got bubble=%0d pc_write=%0d want 0/1", k, obs_bub[k], obs_pcw[k]); end
    end
    step(1, 32'h0000_0000, 32'h28, 0, 0, 5'd7);
    for (int k = 0; k < 2; k++) begin
      checks++; if (obs_bub[k] !== 1'b0 || pc_o[k] !== 32'h28) begin errors++;
        $display("FAIL not_load[%0d] got bubble=%0d pc=%08h want 0/28", k, obs_bub[k], pc_o[k]); end
    end
  endtask

  task automatic test_flush_in_hold();
    step(1, 32'h0043_0820, 32'h30, 0, 0, 5'd0);
    step(1, 32'h1111_1111, 32'h34, 0, 1, 5'd3);
    step(1, 32'h1111_1111, 32'h34, 1, 0, 5'd0);
    checks++; if (obs_bub[1] !== 1'b1 || obs_pcw[1] !== 1'b1) begin errors++;
      $display("FAIL flush_ctrl got bubble=%0d pc_write=%0d want 1/1", obs_bub[1], obs_pcw[1]); end
    checks++; if (valid_o[1] !== 1'b0 || instr_o[1] !== 32'h0 || imm_o[1] !== 32'h0) begin errors++;
      $display("FAIL flush_slot got valid=%0d instr=%08h imm=%08h want 0/0/0", valid_o[1], instr_o[1], imm_o[1]); end
    step(1, 32'h2222_2222, 32'h38, 0, 0, 5'd0);
    checks++; if (obs_pcw[1] !== 1'b1 || obs_bub[1] !== 1'b0 || instr_o[1] !== 32'h2222_2222) begin errors++;
      $display("FAIL flush_abort got pc_write=%0d bubble=%0d instr=%08h want 1/0/22222222", obs_pcw[1], obs_bub[1], instr_o[1]); end
  endtask

  task automatic test_async_reset_mid_hold();
    step(1, 32'h0043_0820, 32'h40, 0, 0, 5'd0);
    step(1, 32'h3333_3333, 32'h44, 0, 1, 5'd2);
    fetch_valid = 1; ex_MemToReg = 0; flush = 0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (valid_o[1] !== 1'b0 || instr_o[1] !== 32'h0 || pc_o[1] !== 32'h0) begin errors++;
      $display("FAIL async_rst_regs got valid=%0d instr=%08h pc=%08h want 0", valid_o[1], instr_o[1], pc_o[1]); end
    checks++; if (bubble_o[1] !== 1'b0 || pcw_o[1] !== 1'b1) begin errors++;
      $display("FAIL async_rst_ctrl got bubble=%0d pc_write=%0d want 0/1", bubble_o[1], pcw_o[1]); end
`ifdef HAZARD_STATS_EN
    checks++; if (sc_o[1] !== 32'h0) begin errors++; $display("FAIL async_rst_stats got %0d want 0", sc_o[1]); end
`endif
    do_reset();
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    for (int h = 0; h < 3; h++) begin
      step(1, 32'h0043_0820, 32'h50, 0, 0, 5'd0);
      step(1, 32'h0000_0000, 32'h54, 0, 1, 5'd2);
      for (int i = 0; i < 3; i++) step(0, 32'h0, 32'h54, 0, 0, 5'd0);
    end
    step(1, 32'h0043_0820, 32'h58, 1, 0, 5'd0);
    checks++; if (sc_o[0] !== 32'd3) begin errors++; $display("FAIL stats_1cyc got %0d want 3", sc_o[0]); end
    checks++; if (sc_o[1] !== 32'd9) begin errors++; $display("FAIL stats_3cyc got %0d want 9", sc_o[1]); end
  endtask
`endif

  task automatic test_random();
    logic [31:0] ins;
    for (int n = 0; n < 300; n++) begin
      ins = $urandom;
      ins[25:21] = 5'($urandom_range(0, 3));
      ins[20:16] = 5'($urandom_range(0, 3));
      step($urandom_range(0, 3) != 0, ins, $urandom, $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)));
      for (int k = 0; k < 2; k++) begin
        checks++; if (obs_bub[k] !== exp_bub[k] || obs_pcw[k] !== exp_pcw[k]) begin errors++;
          $display("FAIL rnd_ctrl[%0d] n=%0d got bubble=%0d pc_write=%0d want %0d/%0d", k, n, obs_bub[k], obs_pcw[k], exp_bub[k], exp_pcw[k]); end
        checks++; if (valid_o[k] !== m_valid[k] || instr_o[k] !== m_instr[k]) begin errors++;
          $display("FAIL rnd_ifid[%0d] n=%0d got valid=%0d instr=%08h want %0d/%08h", k, n, valid_o[k], instr_o[k], m_valid[k], m_instr[k]); end
        if (m_valid[k]) begin
          checks++; if (pc_o[k] !== m_pc[k]) begin errors++;
            $display("FAIL rnd_pc[%0d] n=%0d got %08h want %08h", k, n, pc_o[k], m_pc[k]); end
        end
        checks++; if (rs_o[k] !== m_instr[k][25:21] || rt_o[k] !== m_instr[k][20:16] || rd_o[k] !== m_instr[k][15:11]) begin errors++;
          $display("FAIL rnd_fields[%0d] n=%0d got %0d/%0d/%0d", k, n, rs_o[k], rt_o[k], rd_o[k]); end
        checks++; if ($signed(imm_o[k]) !== 32'($signed(m_instr[k][15:0]))) begin errors++;
          $display("FAIL rnd_imm[%0d] n=%0d got %08h instr %08h", k, n, imm_o[k], m_instr[k]); end
`ifdef HAZARD_STATS_EN
        checks++; if (sc_o[k] !== 32'(m_stats[k])) begin errors++;
          $display("FAIL rnd_stats[%0d] n=%0d got %0d want %0d", k, n, sc_o[k], m_stats[k]); end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load_use_stall();
    test_no_stall();
    test_flush_in_hold();
    test_async_reset_mid_hold();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
